hps_accumulator: RTL and testbench

Signed accumulate-and-requantize stage directly downstream of the precision-scalable signed multiplier. It consumes the multiplier's registered 16-bit signed sub-product sum, one beat per cycle. It accumulates a group of beats into a wide signed accumulator and closes the group on `in_last` or at the maximum group length. Each closed group is emitted as a shifted, saturated `OUT_W`-bit result through a valid/ready output port.

---
 rtl/hps_accumulator.sv | 167 ++++++++++++++++
 tb/tb_hps_accumulator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hps_accumulator.sv
// Signed group accumulator feeding a shift/saturate requantizer, with a two-deep
// (raw result + output register) valid/ready result path.
module hps_accumulator #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      mac_in,
  input  logic             in_valid,
  input  logic             in_last,
  input  logic [4:0]       shift,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_sat,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_CLOSE = {{(CNT_W-1){1'b1}}, 1'b0};
  localparam logic [31:0]      ACC_W_U   = 32'(ACC_W);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic             b_full_q, b_full_d;
  logic [ACC_W-1:0] b_sum_q, b_sum_d;
  logic [CNT_W-1:0] b_cnt_q, b_cnt_d;
  logic             b_ovf_q, b_ovf_d;
  logic [4:0]       b_shift_q, b_shift_d;

  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_sat_q, out_sat_d;
  logic             out_ovf_q, out_ovf_d;
  logic             out_valid_q, out_valid_d;

  logic             in_ready_s, accept_s, close_s, ovf_next_s, b_move_s, sat_s;
  logic [ACC_W-1:0] mac_ext_s, sum_s, shifted_s;
  logic [ACC_W-OUT_W:0] hi_s;
  logic [OUT_W-1:0] clamp_s;

  assign in_ready_s = !(b_full_q && out_valid_q && !out_ready);
  assign accept_s   = in_valid && in_ready_s;
  assign close_s    = accept_s && (in_last || (cnt_q == CNT_CLOSE));
  assign mac_ext_s  = {{(ACC_W-16){mac_in[15]}}, mac_in};
  assign sum_s      = acc_q + mac_ext_s;
  assign ovf_next_s = ovf_q | ((acc_q[ACC_W-1] == mac_in[15]) & (sum_s[ACC_W-1] != acc_q[ACC_W-1]));
  assign b_move_s   = b_full_q && (!out_valid_q || out_ready);

  // requantize the raw result held in stage B; oversized shifts give the sign fill
  always_comb begin
    shifted_s = '0;
    if ({27'd0, b_shift_q} >= ACC_W_U) begin
      shifted_s = {ACC_W{b_sum_q[ACC_W-1]}};
    end else begin
      shifted_s = $signed(b_sum_q) >>> b_shift_q;
    end
    hi_s  = shifted_s[ACC_W-1:OUT_W-1];
    sat_s = !((&hi_s) || !(|hi_s));
    if (sat_s) begin
      clamp_s = {shifted_s[ACC_W-1], {(OUT_W-1){~shifted_s[ACC_W-1]}}};
    end else begin
      clamp_s = shifted_s[OUT_W-1:0];
    end
  end

  // next state of the accumulator, stage B and the output register
  always_comb begin
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    b_full_d    = b_full_q;
    b_sum_d     = b_sum_q;
    b_cnt_d     = b_cnt_q;
    b_ovf_d     = b_ovf_q;
    b_shift_d   = b_shift_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_sat_d   = out_sat_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (close_s) begin
      acc_d = '0;
      cnt_d = '0;
      ovf_d = 1'b0;
    end else if (accept_s) begin
      acc_d = sum_s;
      cnt_d = cnt_q + CNT_ONE;
      ovf_d = ovf_next_s;
    end else begin
      acc_d = acc_q;
    end

    // B may be reloaded in the same cycle it drains; in_ready blocks a load into a stuck B
    if (close_s) begin
      b_full_d  = 1'b1;
      b_sum_d   = sum_s;
      b_cnt_d   = cnt_q + CNT_ONE;
      b_ovf_d   = ovf_next_s;
      b_shift_d = shift;
    end else if (b_move_s) begin
      b_full_d = 1'b0;
    end else begin
      b_full_d = b_full_q;
    end

    if (b_move_s) begin
      out_valid_d = 1'b1;
      out_data_d  = clamp_s;
      out_count_d = b_cnt_q;
      out_sat_d   = sat_s;
      out_ovf_d   = b_ovf_q;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      b_full_q    <= 1'b0;
      b_sum_q     <= '0;
      b_cnt_q     <= '0;
      b_ovf_q     <= 1'b0;
      b_shift_q   <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_sat_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      b_full_q    <= b_full_d;
      b_sum_q     <= b_sum_d;
      b_cnt_q     <= b_cnt_d;
      b_ovf_q     <= b_ovf_d;
      b_shift_q   <= b_shift_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_sat_q   <= out_sat_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign out_sat   = out_sat_q;
  assign out_ovf   = out_ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hps_accumulator.sv
// Bench for hps_accumulator: two instances (32/16/8 and 17/16/2) share one stimulus
// stream and are checked every cycle against an arithmetic group/result-queue model.
module tb_hps_accumulator;

  localparam int A0 = 32, O0 = 16, C0 = 8;
  localparam int A1 = 17, O1 = 16, C1 = 2;

  logic clk, rst, in_valid, in_last, out_ready;
  logic [15:0] mac_in;
  logic [4:0]  shift;

  logic d0_in_ready, d0_out_sat, d0_out_ovf, d0_out_valid;
  logic [O0-1:0] d0_out_data;
  logic [C0-1:0] d0_out_count;
  logic d1_in_ready, d1_out_sat, d1_out_ovf, d1_out_valid;
  logic [O1-1:0] d1_out_data;
  logic [C1-1:0] d1_out_count;

  hps_accumulator #(.ACC_W(A0), .OUT_W(O0), .CNT_W(C0)) dut0 (
    .clk(clk), .rst(rst), .mac_in(mac_in), .in_valid(in_valid), .in_last(in_last),
    .shift(shift), .in_ready(d0_in_ready), .out_data(d0_out_data), .out_count(d0_out_count),
    .out_sat(d0_out_sat), .out_ovf(d0_out_ovf), .out_valid(d0_out_valid), .out_ready(out_ready));

  hps_accumulator #(.ACC_W(A1), .OUT_W(O1), .CNT_W(C1)) dut1 (
    .clk(clk), .rst(rst), .mac_in(mac_in), .in_valid(in_valid), .in_last(in_last),
    .shift(shift), .in_ready(d1_in_ready), .out_data(d1_out_data), .out_count(d1_out_count),
    .out_sat(d1_out_sat), .out_ovf(d1_out_ovf), .out_valid(d1_out_valid), .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    longint data;
    longint count;
    bit     sat;
    bit     ovf;
    int     close_e;
  } res_t;

  int total = 0;
  int bad = 0;
  int e_cnt = 0;
  longint acc_m [2];
  longint cnt_m [2];
  bit     ovf_m [2];
  res_t q0[$];
  res_t q1[$];

  task automatic check_val(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap(input longint v, input int a);
    longint m, h, r;
    m = longint'(1) << a;
    h = m >> 1;
    r = (v + h) % m;
    if (r < 0) r = r + m;
    return r - h;
  endfunction

  function automatic longint fshift(input longint v, input int s);
    longint d;
    d = longint'(1) << s;
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic int qsize(input int k);
    return (k == 0) ? q0.size() : q1.size();
  endfunction

  function automatic res_t head(input int k);
    return (k == 0) ? q0[0] : q1[0];
  endfunction

  // a closed group reaches the output one edge after closing, once older results are gone
  function automatic bit head_vis(input int k);
    res_t h;
    if (qsize(k) == 0) return 1'b0;
    h = head(k);
    return (h.close_e + 2) <= e_cnt;
  endfunction

  task automatic model_edge(input int k, input bit v, input longint mv, input bit l,
                            input int s, input bit ordy);
    int a, o, c;
    bit rdy, novf;
    longint raw, nacc, ncnt, t, cl, lim;
    res_t r;
    a = (k == 0) ? A0 : A1;
    o = (k == 0) ? O0 : O1;
    c = (k == 0) ? C0 : C1;
    rdy = !(qsize(k) == 2 && !ordy);
    if (head_vis(k) && ordy) begin
      if (k == 0) r = q0.pop_front();
      else        r = q1.pop_front();
    end
    if (v && rdy) begin
      raw  = acc_m[k] + mv;
      nacc = wrap(raw, a);
      novf = ovf_m[k] || (raw != nacc);
      ncnt = cnt_m[k] + 1;
      if (l || ncnt == (longint'(1) << c) - 1) begin
        t   = fshift(nacc, s);
        lim = longint'(1) << (o - 1);
        cl  = (t > lim - 1) ? lim - 1 : ((t < -lim) ? -lim : t);
        r.data = cl; r.count = ncnt; r.sat = (cl != t); r.ovf = novf; r.close_e = e_cnt;
        if (k == 0) q0.push_back(r);
        else        q1.push_back(r);
        acc_m[k] = 0; cnt_m[k] = 0; ovf_m[k] = 1'b0;
      end else begin
        acc_m[k] = nacc; cnt_m[k] = ncnt; ovf_m[k] = novf;
      end
    end
  endtask

  task automatic compare_inst(input int k);
    longint rdy, vld, dat, cn, sat, ovf;
    bit exp_vld;
    res_t h;
    if (k == 0) begin
      rdy = d0_in_ready; vld = d0_out_valid; dat = longint'($signed(d0_out_data));
      cn = d0_out_count; sat = d0_out_sat; ovf = d0_out_ovf;
    end else begin
      rdy = d1_in_ready; vld = d1_out_valid; dat = longint'($signed(d1_out_data));
      cn = d1_out_count; sat = d1_out_sat; ovf = d1_out_ovf;
    end
    check_val($sformatf("in_ready%0d", k), rdy, longint'(!(qsize(k) == 2 && !out_ready)));
    exp_vld = head_vis(k);
    check_val($sformatf("out_valid%0d", k), vld, longint'(exp_vld));
    if (exp_vld) begin
      h = head(k);
      check_val($sformatf("out_data%0d", k), dat, h.data);
      check_val($sformatf("out_count%0d", k), cn, h.count);
      check_val($sformatf("out_sat%0d", k), sat, longint'(h.sat));
      check_val($sformatf("out_ovf%0d", k), ovf, longint'(h.ovf));
    end
  endtask

  // called just after a falling edge: drive, check, advance one rising edge
  task automatic cycle(input bit v, input int m, input bit l, input int s, input bit ordy);
    longint mv;
    in_valid = v; mac_in = m[15:0]; in_last = l; shift = s[4:0]; out_ready = ordy;
    mv = longint'($signed(m[15:0]));
    #1;
    compare_inst(0);
    compare_inst(1);
    @(posedge clk);
    model_edge(0, v, mv, l, s, ordy);
    model_edge(1, v, mv, l, s, ordy);
    e_cnt++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
    repeat (2) begin
      @(posedge clk);
      e_cnt++;
    end
    for (int k = 0; k < 2; k++) begin
      acc_m[k] = 0; cnt_m[k] = 0; ovf_m[k] = 1'b0;
    end
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("rst_valid0", d0_out_valid, 0);
    check_val("rst_data0", d0_out_data, 0);
    check_val("rst_count0", d0_out_count, 0);
    check_val("rst_sat0", d0_out_sat, 0);
    check_val("rst_ovf0", d0_out_ovf, 0);
    check_val("rst_ready0", d0_in_ready, 1);
    check_val("rst_valid1", d1_out_valid, 0);
    check_val("rst_data1", d1_out_data, 0);
    check_val("rst_ready1", d1_in_ready, 1);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; mac_in = 16'd0; shift = 5'd0; out_ready = 1'b1;
    do_reset();

    // {100,-30,5}: result one edge after the closing edge
    cycle(1'b1, 100, 1'b0, 0, 1'b1);
    cycle(1'b1, -30, 1'b0, 0, 1'b1);
    cycle(1'b1, 5, 1'b1, 0, 1'b1);
    check_val("t1_early_valid", d0_out_valid, 0);
    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    check_val("t1_valid", d0_out_valid, 1);
    check_val("t1_data", longint'($signed(d0_out_data)), 75);
    check_val("t1_count", d0_out_count, 3);
    check_val("t1_sat", d0_out_sat, 0);

    // saturation then shifted
    repeat (2) cycle(1'b1, 16384, 1'b0, 0, 1'b1);
    cycle(1'b1, 16384, 1'b1, 0, 1'b1);
    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    check_val("t2_data", longint'($signed(d0_out_data)), 32767);
    check_val("t2_sat", d0_out_sat, 1);
    repeat (2) cycle(1'b1, 16384, 1'b0, 2, 1'b1);
    cycle(1'b1, 16384, 1'b1, 2, 1'b1);
    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    check_val("t2s_data", longint'($signed(d0_out_data)), 12288);
    check_val("t2s_sat", d0_out_sat, 0);

    // back-to-back single-beat groups
    cycle(1'b1, -7, 1'b1, 0, 1'b1);
    cycle(1'b1, 9, 1'b1, 0, 1'b1);
    cycle(1'b1, -1, 1'b1, 0, 1'b1);
    repeat (3) cycle(1'b0, 0, 1'b0, 0, 1'b1);

    // stalled output: two buffered, third held off until out_ready returns
    cycle(1'b1, 11, 1'b1, 0, 1'b0);
    cycle(1'b1, 22, 1'b1, 0, 1'b0);
    repeat (3) cycle(1'b1, 33, 1'b1, 0, 1'b0);
    check_val("t5_ready_low", d0_in_ready, 0);
    cycle(1'b1, 33, 1'b1, 0, 1'b1);
    repeat (4) cycle(1'b0, 0, 1'b0, 0, 1'b1);

    // forced close every 3 beats on the CNT_W=2 instance
    repeat (9) cycle(1'b1, 1, 1'b0, 0, 1'b1);
    cycle(1'b1, 1, 1'b1, 0, 1'b1);
    repeat (3) cycle(1'b0, 0, 1'b0, 0, 1'b1);

    // wrap on the ACC_W=17 instance, then reset mid-group
    repeat (2) cycle(1'b1, 32767, 1'b0, 0, 1'b1);
    cycle(1'b1, 32767, 1'b1, 0, 1'b1);
    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    check_val("t7_ovf1", d1_out_ovf, 1);
    check_val("t7_data1", longint'($signed(d1_out_data)), -32768);
    check_val("t7_ovf0", d0_out_ovf, 0);
    repeat (2) cycle(1'b1, 50, 1'b0, 0, 1'b1);
    do_reset();
    cycle(1'b1, 5, 1'b1, 0, 1'b1);
    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    check_val("t7_fresh1", longint'($signed(d1_out_data)), 5);
    check_val("t7_fresh_cnt1", d1_out_count, 1);

    // maximum group length on the CNT_W=8 instance
    repeat (255) cycle(1'b1, 1, 1'b0, 0, 1'b1);
    cycle(1'b0, 0, 1'b0, 0, 1'b1);
    check_val("t8_valid0", d0_out_valid, 1);
    check_val("t8_count0", d0_out_count, 255);
    check_val("t8_data0", longint'($signed(d0_out_data)), 255);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, int'($urandom), $urandom_range(0, 3) == 0,
              ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4)),
              $urandom_range(0, 9) < 7);
      end
    end

    repeat (10) cycle(1'b0, 0, 1'b0, 0, 1'b1);
    check_val("drain0", qsize(0), 0);
    check_val("drain1", qsize(1), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
